// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types, default parameters and helpers for the seven-segment scan controller.
package seven_seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam int DEF_NUM_DIGITS   = 4;
   localparam int DEF_SHOW_CYCLES  = 50000;
   localparam int DEF_BLANK_CYCLES = 4;

   // Index of the most significant nonzero nibble; 0 when every nibble is zero.
   function automatic logic [2:0] top_nonzero(input logic [31:0] value);
      logic [2:0] top;
      top = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (value[4*i +: 4] != 4'h0) top = 3'(i);
      end
      return top;
   endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Valid/ready value-load channel feeding the seven-segment scan controller.
interface seven_seg_scan_ctrl_if
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
   logic                    in_valid;
   logic [4*NUM_DIGITS-1:0] in_value;
   logic                    in_ready;

   modport master (output in_valid, output in_value, input in_ready);
   modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Loadable down-counter timing the BLANK and SHOW intervals of the scanner.
module scan_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc,
   output logic             tc_next
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear)                count_d = '0;
      else if (load)            count_d = load_val;
      else if (count_q != '0)   count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign tc      = (count_q == '0);
   assign tc_next = (count_d == '0);
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free shadow/active value commit.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
   parameter int SHOW_CYCLES  = DEF_SHOW_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   seven_seg_scan_ctrl_if.slave  in_bus,
   output logic [3:0]            nib,
   output logic [NUM_DIGITS-1:0] dig_an_n,
   output logic                  frame_done
);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC);
   localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

   scan_state_t             state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    running_q, running_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d, shadow_q;
   logic                    pending_q;
   logic                    xfer, commit;
   logic                    tmr_clear, tmr_load, tmr_tc, tmr_tc_next;
   logic [CW-1:0]           tmr_load_val;
   logic [3:0]              nib_d;
   logic [NUM_DIGITS-1:0]   dig_d;
   logic                    frame_done_d;

   assign in_bus.in_ready = !pending_q;
   assign xfer            = in_bus.in_valid && !pending_q;
   assign commit          = pending_q && (frame_done || !en);
   assign active_d        = commit ? shadow_q : active_q;

   scan_timer #(.WIDTH(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (tmr_clear),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .tc       (tmr_tc),
      .tc_next  (tmr_tc_next)
   );

   // running_q low means the next clock is BLANK clock 1 of digit 0.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      running_d    = running_q;
      tmr_clear    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      if (!en) begin
         state_d   = BLANK;
         idx_d     = '0;
         running_d = 1'b0;
         tmr_clear = 1'b1;
      end else if (!running_q) begin
         state_d      = BLANK;
         idx_d        = '0;
         running_d    = 1'b1;
         tmr_load     = 1'b1;
         tmr_load_val = BLANK_LOAD;
      end else if (tmr_tc) begin
         unique case (state_q)
            BLANK: begin
               state_d      = SHOW;
               tmr_load     = 1'b1;
               tmr_load_val = SHOW_LOAD;
            end
            SHOW: begin
               state_d      = BLANK;
               idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = BLANK_LOAD;
            end
            default: ;
         endcase
      end
   end

`ifdef SEVSEG_LZB_EN
   logic [31:0] active_ext;
   always_comb begin
      active_ext = '0;
      active_ext[4*NUM_DIGITS-1:0] = active_d;
   end
`endif

   // Outputs are computed from next state so nib and anode flip on the same edge.
   always_comb begin
      nib_d        = active_d[{idx_d, 2'b00} +: 4];
      dig_d        = '1;
      frame_done_d = 1'b0;
      if (state_d == SHOW) begin
`ifdef SEVSEG_LZB_EN
         if (int'(idx_d) <= int'(top_nonzero(active_ext))) dig_d[idx_d] = 1'b0;
`else
         dig_d[idx_d] = 1'b0;
`endif
         frame_done_d = (idx_d == LAST_IDX) && tmr_tc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BLANK;
         idx_q      <= '0;
         running_q  <= 1'b0;
         nib        <= 4'h0;
         dig_an_n   <= '1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         running_q  <= running_d;
         nib        <= nib_d;
         dig_an_n   <= dig_d;
         frame_done <= frame_done_d;
      end
   end

   // A held-off offer stays pending until the frame boundary, never overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         active_q <= active_d;
         if (xfer) begin
            shadow_q  <= in_bus.in_value;
            pending_q <= 1'b1;
         end else if (commit) begin
            pending_q <= 1'b0;
         end
      end
   end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter SHOW_CYCLES, default 50000, clocks each digit is lit per slot (>=2).
REQ-003 Parameter BLANK_CYCLES, default 4, clocks all digits are dark between slots for ghosting suppression (>=1).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  scan enable; low forces the display dark.
REQ-007 in_valid  in  1  new display value offered.
REQ-008 in_value  in  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) is the rightmost digit.
REQ-009 in_ready  out  1  controller can accept a value.
REQ-010 nib  out  4  nibble currently routed to the shared hex-to-seven-segment decoder (w=nib[3] .. z=nib[0]).
REQ-011 dig_an_n  out  NUM_DIGITS  active-low digit anodes; at most one bit low at any time.
REQ-012 frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-013 The block SHALL time-share one decoder across all digits using the states BLANK and SHOW, with a digit index idx.
REQ-014 BLANK: dig_an_n all ones for BLANK_CYCLES clocks, then SHOW with the same idx.
REQ-015 SHOW: dig_an_n[idx]=0, others 1, nib=active[idx], for SHOW_CYCLES clocks, then BLANK with idx+1.
REQ-016 idx SHALL wrap from NUM_DIGITS-1 to 0; frame length is NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) clocks.
REQ-017 frame_done SHALL pulse on the last SHOW clock of idx=NUM_DIGITS-1.
REQ-018 nib and dig_an_n SHALL be registered outputs, changing in the same cycle so no digit ever shows another digit's nibble.
REQ-019 Handshake: a transfer occurs when in_valid && in_ready; in_value is captured into a shadow register and a pending flag is set.
REQ-020 in_ready SHALL equal !pending; a value offered while pending is held off, not dropped or overwritten.
REQ-021 Shadow-to-active commit SHALL occur only on the frame_done cycle, clearing pending, so a frame never mixes old and new digits (no tearing).
REQ-022 A transfer and frame_done in the same cycle: the new value becomes pending and is committed at the next frame_done.
REQ-023 en low: state forced to BLANK, idx=0, counters cleared, dig_an_n all ones, frame_done 0; the handshake and pending commit still operate, with commit taking effect immediately while en is low.
REQ-024 en rising: scanning restarts at BLANK, idx=0, with a full BLANK_CYCLES interval.

Reset
REQ-025 While rst_n=0: state=BLANK, idx=0, counter=0, active=0, shadow=0, pending=0, nib=0, dig_an_n all ones, frame_done=0, in_ready=1.
REQ-026 Reset asserted mid-frame SHALL darken all digits immediately (asynchronous) and discard any pending value.
REQ-027 The first clock after rst_n rises SHALL be BLANK clock 1 of idx 0.

Configuration
REQ-028 Macro SEVSEG_LZB_EN: when defined, the block blanks leading zeros. Any digit above the most significant nonzero nibble of active keeps its anode high during its SHOW slot; digit 0 is always lit; slot timing is unchanged.
REQ-029 When SEVSEG_LZB_EN is undefined, all digits are lit in their slots, including leading zeros.

Structure
REQ-030 Package seven_seg_pkg SHALL hold the state type (BLANK, SHOW) and the default values of NUM_DIGITS, SHOW_CYCLES and BLANK_CYCLES.
REQ-031 One sub-module, scan_timer (a loadable down-counter with terminal-count output), SHALL time both states; the decoder itself stays outside this block.

Verification (NUM_DIGITS=4, SHOW_CYCLES=8, BLANK_CYCLES=2)
REQ-032 Release reset with en=1 -> dig_an_n=1111 for 2 clocks, then 1110 for 8 clocks with nib=0, then 1111 for 2 clocks, then 1101; frame_done pulses every 40 clocks.
REQ-033 Offer in_value=16'h12A4 mid-frame -> in_ready drops the next cycle; nib values stay unchanged until frame_done; the next frame shows 4, A, 2, 1 on digits 0..3; in_ready returns to 1.
REQ-034 Offer 16'h1111 then, while pending, 16'h2222 held valid -> 16'h1111 is committed first, 16'h2222 is accepted after that commit, and it is displayed one frame later.
REQ-035 Deassert en during SHOW of idx 2 -> dig_an_n=1111 the next clock; on en high, 2 BLANK clocks then idx 0 is lit.
REQ-036 With SEVSEG_LZB_EN, active=16'h0050 -> digits 3 and 2 are never lit, digits 1 and 0 are lit (showing 5 and 0); active=16'h0000 -> only digit 0 is lit.
REQ-037 Pulse rst_n low during SHOW with a value pending -> all anodes go high asynchronously; after release active=0, pending=0, and REQ-032 timing repeats.
